// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with round-robin soft-reset requests
module reset_sequencer #(
    parameter logic [31:0] STAGE_DELAY = 32'd25000000,
    parameter logic [31:0] SOFT_HOLD   = 32'd1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] soft_req,
    output logic [1:0] soft_ack,
    output logic [2:0] stage_rst,
    output logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {HOLD, WAIT1, WAIT2, RUN} state_t;

    state_t      state, state_nx;
    logic [1:0]  sync;
    logic [31:0] count, count_nx;
    logic [31:0] limit;
    logic        count_done;
    logic        soft_len, soft_len_nx;
    logic [1:0]  arm, arm_nx;
    logic        last, last_nx;
    logic [2:0]  stage_nx;
    logic        ready_nx;
    logic [1:0]  ack_nx;
    logic [1:0]  cand;
    logic        grant_idx;

    // Assertion is asynchronous through the flop clears; release is delayed two edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign limit      = (state == HOLD) ? (soft_len ? SOFT_HOLD : STAGE_DELAY) : STAGE_DELAY;
    assign count_done = (count == limit - 32'd1);
    assign cand       = soft_req & arm;
    assign grant_idx  = (cand == 2'b11) ? ~last : cand[1];
    assign busy       = ~ready;

    always_comb begin
        state_nx    = state;
        count_nx    = count + 32'd1;
        soft_len_nx = soft_len;
        arm_nx      = arm | ~soft_req;
        last_nx     = last;
        stage_nx    = stage_rst;
        ready_nx    = ready;
        ack_nx      = 2'b00;

        case (state)
            HOLD: begin
                if (count_done) begin
                    stage_nx = 3'b110;
                    state_nx = WAIT1;
                    count_nx = 32'd0;
                end
            end
            WAIT1: begin
                if (count_done) begin
                    stage_nx = 3'b100;
                    state_nx = WAIT2;
                    count_nx = 32'd0;
                end
            end
            WAIT2: begin
                if (count_done) begin
                    stage_nx = 3'b000;
                    ready_nx = 1'b1;
                    state_nx = RUN;
                    count_nx = 32'd0;
                end
            end
            default: begin
                count_nx = 32'd0;
                if (cand != 2'b00) begin
                    ack_nx              = grant_idx ? 2'b10 : 2'b01;
                    stage_nx            = 3'b111;
                    ready_nx            = 1'b0;
                    state_nx            = HOLD;
                    soft_len_nx         = 1'b1;
                    last_nx             = grant_idx;
                    arm_nx[grant_idx]   = 1'b0;
                end
            end
        endcase

        // Synchronised reset still held: keep everything at its power-up values.
        if (!sync[1]) begin
            state_nx    = HOLD;
            count_nx    = 32'd0;
            soft_len_nx = 1'b0;
            arm_nx      = 2'b11;
            last_nx     = 1'b1;
            stage_nx    = 3'b111;
            ready_nx    = 1'b0;
            ack_nx      = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HOLD;
            count     <= 32'd0;
            soft_len  <= 1'b0;
            arm       <= 2'b11;
            last      <= 1'b1;
            stage_rst <= 3'b111;
            ready     <= 1'b0;
            soft_ack  <= 2'b00;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            soft_len  <= soft_len_nx;
            arm       <= arm_nx;
            last      <= last_nx;
            stage_rst <= stage_nx;
            ready     <= ready_nx;
            soft_ack  <= ack_nx;
        end
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGE_DELAY, default 25000000, clock cycles between successive stage releases (legal 1..2^32-1).
REQ-002 SHALL have parameter SOFT_HOLD, default 1000, clock cycles all stages are held after an accepted soft request (legal 1..2^32-1).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low block reset.
REQ-005 SHALL have port soft_req  input  2  level soft-reset requests; bit i belongs to requester i.
REQ-006 SHALL have port soft_ack  output  2  one-cycle grant pulse to the accepted requester.
REQ-007 SHALL have port stage_rst  output  3  active-high downstream resets; stage 0 releases first.
REQ-008 SHALL have port ready  output  1  high only while all three stages are released.
REQ-009 SHALL have port busy  output  1  high whenever ready is low.

Function
REQ-010 SHALL deassert the internal reset through a 2-flop synchronizer, so internal reset release occurs on the second rising edge after reset_n goes high; assertion stays asynchronous.
REQ-011 SHALL implement FSM states HOLD, WAIT1, WAIT2, RUN with one 32-bit down/up delay counter.
REQ-012 HOLD: stage_rst=3'b111; counter runs for HOLD_LEN cycles, then stage_rst[0]<=0 and go to WAIT1.
REQ-013 HOLD_LEN SHALL be STAGE_DELAY after block reset and SOFT_HOLD after an accepted soft request.
REQ-014 WAIT1: after STAGE_DELAY cycles, stage_rst[1]<=0, go to WAIT2.
REQ-015 WAIT2: after STAGE_DELAY cycles, stage_rst[2]<=0, ready<=1, go to RUN, all in the same edge.
REQ-016 Counter SHALL clear on every state entry; no state SHALL leave before its full count (STAGE_DELAY=1 gives releases on consecutive edges).
REQ-017 RUN: if an armed request is high, SHALL pulse the granted soft_ack bit for exactly one cycle, set stage_rst=3'b111, ready<=0, and enter HOLD with HOLD_LEN=SOFT_HOLD, all on one edge.
REQ-018 Each requester SHALL have an arm flag: set by reset, cleared on grant, re-set only after soft_req[i] is sampled low; a held-high request SHALL never be granted twice.
REQ-019 Requests in HOLD/WAIT1/WAIT2 SHALL be ignored (no ack, not queued); a request still high and armed on RUN entry SHALL be granted on the first RUN edge.
REQ-020 Arbitration SHALL be round-robin: with both armed and high, grant the requester not granted last; last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-021 soft_ack SHALL be one-hot or zero at all times.
REQ-022 stage_rst[k] SHALL never be low while stage_rst[k-1] is high (ordered release, simultaneous reassert).

Reset
REQ-023 While reset_n is low: stage_rst=3'b111, soft_ack=0, ready=0, busy=1, state HOLD, counter=0, arm flags=1, pointer=1, asynchronously.
REQ-024 reset_n asserted mid-sequence or in RUN SHALL immediately force REQ-023 values; after release the full power-up sequence with HOLD_LEN=STAGE_DELAY restarts.

Verification
REQ-025 STAGE_DELAY=4: release reset_n -> stage_rst goes 111->110->100->000 at 4-cycle spacing after internal release; ready rises with last step; busy is its inverse.
REQ-026 RUN, SOFT_HOLD=3, soft_req=2'b01 for 10 cycles -> soft_ack=2'b01 for one cycle, stage_rst=111 for 3 cycles then staged release; no second ack until soft_req drops and rises again.
REQ-027 RUN, soft_req=2'b11 repeatedly (toggled low between) -> acks alternate 01,10,01; first is 01.
REQ-028 soft_req=2'b10 during WAIT1 -> no ack until RUN; ack 2'b10 on first RUN edge.
REQ-029 reset_n pulsed low during WAIT2 -> stage_rst=111, ready=0 same instant; full sequence restarts with STAGE_DELAY hold.
REQ-030 STAGE_DELAY=1, SOFT_HOLD=1 -> release on consecutive edges; ordering assertion REQ-022 holds throughout.
